// File: rtl/mac_core.sv
// mac_core: row-strided matrix multiply C = A x B over a shared data memory.
// Ports: clk, rst_n, en, core_id, dim_m/n/p, base_a/b/c, dm_* memory bus, busy, end_op.
module mac_core #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int NCORES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [7:0]        core_id,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_p,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_rd,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_rvalid,
    output logic              dm_wr,
    output logic [ACC_W-1:0]  dm_wdata,
    output logic              busy,
    output logic              end_op
);

    // Row index is wide enough that i + NCORES never wraps before the M compare.
    localparam int IW = DIM_W + 8;
    localparam logic [DIM_W-1:0]  D1 = DIM_W'(1);
    localparam logic [ADDR_W-1:0] A1 = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE, CLR, RD_A, WAIT_A, RD_B, WAIT_B, WR, DONE
    } state_t;

    state_t              state_q;
    logic [DIM_W-1:0]    m_q, n_q, p_q;
    logic [DIM_W-1:0]    j_q, k_q;
    logic [IW-1:0]       i_q;
    logic [ADDR_W-1:0]   base_a_q, base_b_q, base_c_q;
    logic [DATA_W-1:0]   a_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ADDR_W-1:0]   dm_addr_q;
    logic                dm_rd_q, dm_wr_q;
    logic [ACC_W-1:0]    dm_wdata_q;
    logic                busy_q, end_op_q;

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_d;
    logic [IW-1:0]       i_d;
    logic                start_bad;
    logic [ADDR_W-1:0]   addr_a0, addr_a_nx, addr_b, addr_c;

    assign prod  = (2*DATA_W)'(a_q) * (2*DATA_W)'(dm_rdata);
    assign acc_d = acc_q + ACC_W'(prod);
    assign i_d   = i_q + IW'(NCORES);

    assign start_bad = (dim_m == '0) || (dim_n == '0) || (dim_p == '0)
                    || (IW'(core_id) >= IW'(dim_m));

    // addr_a0 is A[i][0]; addr_a_nx is A[i][k+1] for the next k step.
    assign addr_a0   = base_a_q + ADDR_W'(i_q) * ADDR_W'(n_q);
    assign addr_a_nx = addr_a0 + ADDR_W'(k_q) + A1;
    assign addr_b    = base_b_q + ADDR_W'(k_q) * ADDR_W'(p_q)
                     + ADDR_W'(j_q);
    assign addr_c    = base_c_q + ADDR_W'(i_q) * ADDR_W'(p_q)
                     + ADDR_W'(j_q);

    // Outputs are registered and set on entry to the state that owns them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            m_q        <= '0;
            n_q        <= '0;
            p_q        <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            base_a_q   <= '0;
            base_b_q   <= '0;
            base_c_q   <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            dm_addr_q  <= '0;
            dm_rd_q    <= 1'b0;
            dm_wr_q    <= 1'b0;
            dm_wdata_q <= '0;
            busy_q     <= 1'b0;
            end_op_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (en) begin
                    m_q      <= dim_m;
                    n_q      <= dim_n;
                    p_q      <= dim_p;
                    base_a_q <= base_a;
                    base_b_q <= base_b;
                    base_c_q <= base_c;
                    i_q      <= IW'(core_id);
                    j_q      <= '0;
                    if (start_bad) begin
                        state_q  <= DONE;
                        end_op_q <= 1'b1;
                    end else begin
                        state_q <= CLR;
                        busy_q  <= 1'b1;
                    end
                end
                CLR: begin
                    acc_q     <= '0;
                    k_q       <= '0;
                    dm_rd_q   <= 1'b1;
                    dm_addr_q <= addr_a0;
                    state_q   <= RD_A;
                end
                RD_A: begin
                    dm_rd_q <= 1'b0;
                    state_q <= WAIT_A;
                end
                WAIT_A: if (dm_rvalid) begin
                    a_q       <= dm_rdata;
                    dm_rd_q   <= 1'b1;
                    dm_addr_q <= addr_b;
                    state_q   <= RD_B;
                end
                RD_B: begin
                    dm_rd_q <= 1'b0;
                    state_q <= WAIT_B;
                end
                WAIT_B: if (dm_rvalid) begin
                    acc_q <= acc_d;
                    if (k_q == n_q - D1) begin
                        dm_wr_q    <= 1'b1;
                        dm_addr_q  <= addr_c;
                        dm_wdata_q <= acc_d;
                        state_q    <= WR;
                    end else begin
                        k_q       <= k_q + D1;
                        dm_rd_q   <= 1'b1;
                        dm_addr_q <= addr_a_nx;
                        state_q   <= RD_A;
                    end
                end
                WR: begin
                    dm_wr_q    <= 1'b0;
                    dm_wdata_q <= '0;
                    if (j_q != p_q - D1) begin
                        j_q     <= j_q + D1;
                        state_q <= CLR;
                    end else begin
                        j_q <= '0;
                        i_q <= i_d;
                        if (i_d >= IW'(m_q)) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            end_op_q <= 1'b1;
                        end else begin
                            state_q <= CLR;
                        end
                    end
                end
                DONE: if (!en) begin
                    state_q  <= IDLE;
                    end_op_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dm_addr  = dm_addr_q;
    assign dm_rd    = dm_rd_q;
    assign dm_wr    = dm_wr_q;
    assign dm_wdata = dm_wdata_q;
    assign busy     = busy_q;
    assign end_op   = end_op_q;

endmodule

// File: tb/tb_mac_core.sv
// tb_mac_core: directed vector bench for mac_core, two instances
// (NCORES=1 and NCORES=2) each with its own memory responder.
module tb_mac_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en [2];
    logic [7:0]  core_id, dim_m, dim_n, dim_p;
    logic [15:0] base_a, base_b, base_c;
    logic [15:0] dm_addr [2];
    logic        dm_rd [2];
    logic        dm_wr [2];
    logic [15:0] dm_wdata [2];
    logic        busy [2];
    logic        end_op [2];
    logic [7:0]  rdat [2];
    logic        rv_q [2];
    logic        rvalid [2];

    always #5 clk = ~clk;

    mac_core #(.NCORES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .core_id(core_id),
        .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .dm_addr(dm_addr[0]), .dm_rd(dm_rd[0]), .dm_rdata(rdat[0]),
        .dm_rvalid(rvalid[0]), .dm_wr(dm_wr[0]), .dm_wdata(dm_wdata[0]),
        .busy(busy[0]), .end_op(end_op[0])
    );

    mac_core #(.NCORES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .core_id(core_id),
        .dim_m(dim_m), .dim_n(dim_n), .dim_p(dim_p),
        .base_a(base_a), .base_b(base_b), .base_c(base_c),
        .dm_addr(dm_addr[1]), .dm_rd(dm_rd[1]), .dm_rdata(rdat[1]),
        .dm_rvalid(rvalid[1]), .dm_wr(dm_wr[1]), .dm_wdata(dm_wdata[1]),
        .busy(busy[1]), .end_op(end_op[1])
    );

    logic [7:0]  mem [256];
    int          lat;
    logic        spur;
    int          sel;
    logic        pend [2];
    int          cnt [2];
    logic [7:0]  paddr [2];

    // Spurious rvalid rides along with dm_rd, i.e. while the DUT is in RD_A/RD_B.
    assign rvalid[0] = rv_q[0] | (spur & dm_rd[0]);
    assign rvalid[1] = rv_q[1] | (spur & dm_rd[1]);

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            rv_q[g] <= 1'b0;
            if (pend[g]) begin
                if (cnt[g] == 1) begin
                    rv_q[g]  <= 1'b1;
                    rdat[g]  <= mem[paddr[g]];
                    pend[g]  <= 1'b0;
                end else begin
                    cnt[g] <= cnt[g] - 1;
                end
            end
            if (dm_rd[g]) begin
                if (lat == 1) begin
                    rv_q[g] <= 1'b1;
                    rdat[g] <= mem[dm_addr[g][7:0]];
                end else begin
                    pend[g]  <= 1'b1;
                    cnt[g]   <= lat - 1;
                    paddr[g] <= dm_addr[g][7:0];
                end
            end
        end
    end

    logic [15:0] waddr [$];
    logic [15:0] wdata [$];
    int          rdcnt;
    logic        overlap;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dm_wr[sel]) begin
                waddr.push_back(dm_addr[sel]);
                wdata.push_back(dm_wdata[sel]);
            end
            if (dm_rd[sel]) rdcnt++;
            if ((dm_rd[0] && dm_wr[0]) || (dm_rd[1] && dm_wr[1]))
                overlap = 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic             inst;
        logic [7:0]       cid, m, n, p;
        logic [15:0]      ba, bb, bc;
        logic [3:0]       lat;
        logic             spur, drop;
        logic [3:0]       nwr;
        logic [7:0]       nrd;
        logic [3:0][15:0] ea, ed;
    } vec_t;

    function automatic vec_t mk(
        input logic inst, input logic [7:0] cid, m, n, p,
        input logic [15:0] ba, bb, bc, input logic [3:0] l,
        input logic sp, dr, input logic [3:0] nwr,
        input logic [7:0] nrd, input logic [63:0] ea, ed);
        vec_t v;
        v.inst = inst; v.cid = cid; v.m = m; v.n = n; v.p = p;
        v.ba = ba; v.bb = bb; v.bc = bc; v.lat = l;
        v.spur = sp; v.drop = dr; v.nwr = nwr; v.nrd = nrd;
        v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic load_cfg(input vec_t v);
        core_id = v.cid; dim_m = v.m; dim_n = v.n; dim_p = v.p;
        base_a = v.ba; base_b = v.bb; base_c = v.bc;
    endtask

    task automatic run_vec(input vec_t v, input string id);
        int cyc;
        sel = int'(v.inst); lat = int'(v.lat); spur = v.spur;
        waddr.delete(); wdata.delete(); rdcnt = 0; overlap = 1'b0;
        load_cfg(v);
        en[sel] = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        chk({id, " start_busy"}, 32'(busy[sel]), 32'(v.nwr != 0));
        chk({id, " start_end"}, 32'(end_op[sel]), 32'(v.nwr == 0));
        core_id = 8'($urandom); dim_m = 8'($urandom);
        dim_n = 8'($urandom);   dim_p = 8'($urandom);
        base_a = 16'($urandom); base_b = 16'($urandom);
        base_c = 16'($urandom);
        if (v.drop) en[sel] = 1'b0;
        while (!end_op[sel] && cyc < 600) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({id, " end_op"}, 32'(end_op[sel]), 1);
        if (v.nwr == 0) chk({id, " latency"}, cyc, 1);
        chk({id, " done_busy"}, 32'(busy[sel]), 0);
        chk({id, " done_wdata"}, 32'(dm_wdata[sel]), 0);
        chk({id, " nwr"}, waddr.size(), 32'(v.nwr));
        for (int w = 0; w < int'(v.nwr) && w < waddr.size(); w++) begin
            chk($sformatf("%s waddr%0d", id, w), 32'(waddr[w]),
                32'(v.ea[w]));
            chk($sformatf("%s wdata%0d", id, w), 32'(wdata[w]),
                32'(v.ed[w]));
        end
        chk({id, " nrd"}, rdcnt, 32'(v.nrd));
        chk({id, " rd_wr_overlap"}, 32'(overlap), 0);
        en[sel] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk({id, " idle_end"}, 32'(end_op[sel]), 0);
    endtask

    vec_t tbl [7];

    initial begin
        int n;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        for (int a = 0; a < 4; a++) mem[a] = 8'(a + 1);
        for (int a = 0; a < 6; a++) mem[8'h30 + a] = 8'(a + 1);
        for (int a = 0; a < 6; a++) mem[8'h10 + a] = 8'(a + 5);
        for (int a = 0; a < 4; a++) mem[8'h40 + a] = 8'hFF;

        tbl[0] = mk(0, 0, 2, 2, 2, 16'h0, 16'h10, 16'h20, 1, 0, 0, 4, 16,
                    {16'h23, 16'h22, 16'h21, 16'h20},
                    {16'd50, 16'd43, 16'd22, 16'd19});
        tbl[1] = mk(0, 0, 2, 2, 2, 16'h0, 16'h10, 16'h20, 3, 1, 0, 4, 16,
                    {16'h23, 16'h22, 16'h21, 16'h20},
                    {16'd50, 16'd43, 16'd22, 16'd19});
        tbl[2] = mk(1, 1, 3, 2, 2, 16'h30, 16'h10, 16'h80, 1, 0, 1, 2, 8,
                    {16'h0, 16'h0, 16'h83, 16'h82},
                    {16'd0, 16'd0, 16'd50, 16'd43});
        tbl[3] = mk(0, 0, 1, 2, 1, 16'h40, 16'h40, 16'h50, 2, 0, 0, 1, 4,
                    {16'h0, 16'h0, 16'h0, 16'h50},
                    {16'd0, 16'd0, 16'd0, 16'd64514});
        tbl[4] = mk(0, 5, 3, 2, 2, 16'h0, 16'h10, 16'h20, 1, 0, 0, 0, 0,
                    64'h0, 64'h0);
        tbl[5] = mk(0, 0, 2, 0, 2, 16'h0, 16'h10, 16'h20, 1, 0, 0, 0, 0,
                    64'h0, 64'h0);
        tbl[6] = mk(0, 0, 1, 3, 2, 16'h0, 16'h10, 16'hFFFF, 1, 0, 0, 2, 12,
                    {16'h0, 16'h0, 16'h0000, 16'hFFFF},
                    {16'd0, 16'd0, 16'd52, 16'd46});

        sel = 0; lat = 1; spur = 1'b0; rdcnt = 0; overlap = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        en[0] = 1'b0; en[1] = 1'b0;
        load_cfg(tbl[0]);
        rst_n = 1'b0;
        #12;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst%0d busy", g), 32'(busy[g]), 0);
            chk($sformatf("rst%0d end_op", g), 32'(end_op[g]), 0);
            chk($sformatf("rst%0d dm_rd", g), 32'(dm_rd[g]), 0);
            chk($sformatf("rst%0d dm_wr", g), 32'(dm_wr[g]), 0);
            chk($sformatf("rst%0d dm_addr", g), 32'(dm_addr[g]), 0);
            chk($sformatf("rst%0d dm_wdata", g), 32'(dm_wdata[g]), 0);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 7; t++)
            run_vec(tbl[t], $sformatf("v%0d", t));

        sel = 0; lat = 3; spur = 1'b0; rdcnt = 0;
        load_cfg(tbl[0]);
        en[0] = 1'b1;
        n = 0;
        while (rdcnt < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid reach_rd_b", rdcnt, 2);
        @(posedge clk); #3;
        chk("mid busy", 32'(busy[0]), 1);
        chk("mid dm_addr", 32'(dm_addr[0]), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", 32'(busy[0]), 0);
        chk("mid_rst end_op", 32'(end_op[0]), 0);
        chk("mid_rst dm_rd", 32'(dm_rd[0]), 0);
        chk("mid_rst dm_wr", 32'(dm_wr[0]), 0);
        chk("mid_rst dm_addr", 32'(dm_addr[0]), 0);
        chk("mid_rst dm_wdata", 32'(dm_wdata[0]), 0);
        en[0] = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst busy", 32'(busy[0]), 0);
        chk("post_rst dm_rd", 32'(dm_rd[0]), 0);
        run_vec(tbl[1], "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
